// File: rtl/alu_result_pipe_if.sv
// alu_result_pipe_if: operation inputs, pipeline control and result/flag outputs of alu_result_pipe.
interface alu_result_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [2:0]       ctrl;
    logic             set_flags;
    logic [WIDTH-1:0] pass_i;
    logic [WIDTH-1:0] add_i;
    logic [WIDTH-1:0] sub_i;
    logic [WIDTH-1:0] xor_i;
    logic [WIDTH-1:0] and_i;
    logic [WIDTH-1:0] or_i;
    logic             add_c;
    logic             add_v;
    logic             sub_c;
    logic             sub_v;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             illegal;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, ctrl, set_flags, pass_i, add_i, sub_i, xor_i, and_i, or_i,
               add_c, add_v, sub_c, sub_v, stall, flush,
        input  out_valid, result, illegal, flag_n, flag_z, flag_c, flag_v
    );

    modport slave (
        input  in_valid, ctrl, set_flags, pass_i, add_i, sub_i, xor_i, and_i, or_i,
               add_c, add_v, sub_c, sub_v, stall, flush,
        output out_valid, result, illegal, flag_n, flag_z, flag_c, flag_v
    );
endinterface

// File: rtl/alu_result_pipe.sv
// alu_result_pipe: selects one ALU result by ctrl, pipelines it 1 or 2 stages and keeps the NZCV flags.
module alu_result_pipe #(
    parameter int WIDTH = 64,
    parameter int PIPE  = 2
) (
    input logic             clk,
    input logic             reset,
    alu_result_pipe_if.slave bus
);
    if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
        $error("alu_result_pipe: PIPE must be 1 or 2");
    end

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic             sf;
        logic             ill;
    } op_t;

    op_t              in_op;
    op_t              fin_in;
    logic             src_valid;
    logic             fin_valid;
    logic [WIDTH-1:0] fin_res;
    logic             fin_ill;
    logic [3:0]       nzcv;

    always_comb begin
        in_op.ill = bus.ctrl == 3'b001 || bus.ctrl == 3'b111;
        in_op.res = bus.ctrl == 3'b000 ? bus.pass_i :
                    bus.ctrl == 3'b010 ? bus.add_i :
                    bus.ctrl == 3'b011 ? bus.sub_i :
                    bus.ctrl == 3'b110 ? bus.xor_i :
                    bus.ctrl == 3'b100 ? bus.and_i :
                    bus.ctrl == 3'b101 ? bus.or_i : '0;
        in_op.c   = bus.ctrl == 3'b010 ? bus.add_c : bus.ctrl == 3'b011 ? bus.sub_c : 1'b0;
        in_op.v   = bus.ctrl == 3'b010 ? bus.add_v : bus.ctrl == 3'b011 ? bus.sub_v : 1'b0;
        in_op.sf  = bus.set_flags;
    end

    // With two stages the final stage is fed by stage A; with one it is fed straight from the inputs.
    if (PIPE == 2) begin : g_two
        op_t  a_op;
        logic a_valid;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_valid <= 1'b0;
                a_op    <= '0;
            end else if (bus.flush) begin
                a_valid <= 1'b0;
            end else if (!bus.stall) begin
                a_valid <= bus.in_valid;
                if (bus.in_valid) a_op <= in_op;
            end
        end
        assign fin_in    = a_op;
        assign src_valid = a_valid;
    end else begin : g_one
        assign fin_in    = in_op;
        assign src_valid = bus.in_valid;
    end

    // Data and flags only move when a valid op enters, so they hold across bubbles, stalls and flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fin_valid <= 1'b0;
            fin_res   <= '0;
            fin_ill   <= 1'b0;
            nzcv      <= 4'b0000;
        end else if (bus.flush) begin
            fin_valid <= 1'b0;
        end else if (!bus.stall) begin
            fin_valid <= src_valid;
            if (src_valid) begin
                fin_res <= fin_in.res;
                fin_ill <= fin_in.ill;
                if (fin_in.sf && !fin_in.ill)
                    nzcv <= {fin_in.res[WIDTH-1], fin_in.res == '0, fin_in.c, fin_in.v};
            end
        end
    end

    assign bus.out_valid = fin_valid;
    assign bus.result    = fin_res;
    assign bus.illegal   = fin_ill;
    assign {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v} = nzcv;
endmodule

// File: tb/tb_alu_result_pipe.sv
// tb_alu_result_pipe: drives PIPE=2 and PIPE=1 instances with the same stimulus and checks both
// against an age-based queue model of in-flight ops and architectural flags.
module tb_alu_result_pipe;
    localparam int W = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, set_flags = 1'b0, stall = 1'b0, flush = 1'b0;
    logic         add_c = 1'b0, add_v = 1'b0, sub_c = 1'b0, sub_v = 1'b0;
    logic [2:0]   ctrl = 3'b000;
    logic [W-1:0] pass_i = '0, add_i = '0, sub_i = '0, xor_i = '0, and_i = '0, or_i = '0;

    alu_result_pipe_if #(.WIDTH(W)) i2 ();
    alu_result_pipe_if #(.WIDTH(W)) i1 ();

    assign {i2.in_valid, i2.ctrl, i2.set_flags, i2.add_c, i2.add_v, i2.sub_c, i2.sub_v, i2.stall, i2.flush} =
           {in_valid, ctrl, set_flags, add_c, add_v, sub_c, sub_v, stall, flush};
    assign {i2.pass_i, i2.add_i, i2.sub_i, i2.xor_i, i2.and_i, i2.or_i} = {pass_i, add_i, sub_i, xor_i, and_i, or_i};
    assign {i1.in_valid, i1.ctrl, i1.set_flags, i1.add_c, i1.add_v, i1.sub_c, i1.sub_v, i1.stall, i1.flush} =
           {in_valid, ctrl, set_flags, add_c, add_v, sub_c, sub_v, stall, flush};
    assign {i1.pass_i, i1.add_i, i1.sub_i, i1.xor_i, i1.and_i, i1.or_i} = {pass_i, add_i, sub_i, xor_i, and_i, or_i};

    alu_result_pipe #(.WIDTH(W), .PIPE(2)) dut2 (.clk(clk), .reset(reset), .bus(i2));
    alu_result_pipe #(.WIDTH(W), .PIPE(1)) dut1 (.clk(clk), .reset(reset), .bus(i1));

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Model: each accepted op ages by one per non-stalled edge and retires when its age reaches the depth.
    typedef struct {
        int           d;
        int           age;
        logic [W-1:0] res;
        logic         c, v, sf, ill;
    } ent_t;

    ent_t         pend[$];
    logic         m_ov[2];
    logic [W-1:0] m_res[2];
    logic         m_ill[2];
    logic [3:0]   m_fl[2];

    function automatic ent_t expect_op(input int d);
        ent_t e;
        e.d = d; e.age = 1; e.sf = set_flags; e.ill = 1'b0; e.c = 1'b0; e.v = 1'b0; e.res = '0;
        case (ctrl)
            3'b000: e.res = pass_i;
            3'b010: begin e.res = add_i; e.c = add_c; e.v = add_v; end
            3'b011: begin e.res = sub_i; e.c = sub_c; e.v = sub_v; end
            3'b110: e.res = xor_i;
            3'b100: e.res = and_i;
            3'b101: e.res = or_i;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic model_reset;
        pend.delete();
        for (int d = 0; d < 2; d++) begin
            m_ov[d] = 1'b0; m_res[d] = '0; m_ill[d] = 1'b0; m_fl[d] = 4'b0000;
        end
    endtask

    task automatic retire(input ent_t e);
        m_ov[e.d]  = 1'b1;
        m_res[e.d] = e.res;
        m_ill[e.d] = e.ill;
        if (e.sf && !e.ill) m_fl[e.d] = {e.res[W-1], e.res == '0, e.c, e.v};
    endtask

    task automatic model_edge;
        if (reset) begin
            model_reset();
        end else if (flush) begin
            pend.delete();
            m_ov[0] = 1'b0; m_ov[1] = 1'b0;
        end else if (!stall) begin
            m_ov[0] = 1'b0; m_ov[1] = 1'b0;
            foreach (pend[i]) pend[i].age++;
            if (in_valid) begin
                pend.push_back(expect_op(0));
                pend.push_back(expect_op(1));
            end
            for (int i = pend.size() - 1; i >= 0; i--)
                if (pend[i].age == (pend[i].d == 0 ? 2 : 1)) begin
                    retire(pend[i]);
                    pend.delete(i);
                end
        end
    endtask

    task automatic compare;
        chk("p2_status", 64'({i2.out_valid, i2.illegal, i2.flag_n, i2.flag_z, i2.flag_c, i2.flag_v}),
            64'({m_ov[0], m_ill[0], m_fl[0]}));
        chk("p2_result", i2.result, m_res[0]);
        chk("p1_status", 64'({i1.out_valid, i1.illegal, i1.flag_n, i1.flag_z, i1.flag_c, i1.flag_v}),
            64'({m_ov[1], m_ill[1], m_fl[1]}));
        chk("p1_result", i1.result, m_res[1]);
    endtask

    task automatic step;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    function automatic logic [W-1:0] rnd64();
        return ($urandom_range(3) == 0) ? '0 : {$urandom, $urandom};
    endfunction

    task automatic set_op(input logic [2:0] c, input logic sf, input logic [W-1:0] val);
        in_valid = 1'b1; ctrl = c; set_flags = sf;
        add_c = 1'b0; add_v = 1'b0; sub_c = 1'b0; sub_v = 1'b0;
        pass_i = rnd64(); add_i = rnd64(); sub_i = rnd64(); xor_i = rnd64(); and_i = rnd64(); or_i = rnd64();
        case (c)
            3'b000: pass_i = val;
            3'b010: add_i = val;
            3'b011: sub_i = val;
            3'b110: xor_i = val;
            3'b100: and_i = val;
            3'b101: or_i = val;
            default: ;
        endcase
    endtask

    logic [2:0] codes[6] = '{3'b000, 3'b010, 3'b011, 3'b110, 3'b100, 3'b101};

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        reset = 1'b0;

        // reset mid-flight: nothing may surface or write flags afterwards
        set_op(3'b010, 1'b1, 64'd5);
        add_c = 1'b1;
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_async_status", 64'({i2.out_valid, i2.flag_n, i2.flag_z, i2.flag_c, i2.flag_v}), 64'd0);
        chk("rst_async_result", i2.result, 64'd0);
        @(negedge clk);
        step();
        reset = 1'b0;
        repeat (3) step();

        set_op(3'b010, 1'b1, 64'd0);
        add_c = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("add_zero_status", 64'({i2.out_valid, i2.illegal, i2.flag_n, i2.flag_z, i2.flag_c, i2.flag_v}), 64'b10_0110);
        chk("add_zero_result", i2.result, 64'd0);

        set_op(3'b011, 1'b1, {W{1'b1}});
        step();
        set_op(3'b100, 1'b0, 64'd0);
        step();
        in_valid = 1'b0;
        step();
        chk("and_keeps_flags", 64'({i2.out_valid, i2.flag_n, i2.flag_z, i2.flag_c, i2.flag_v}), 64'b1_1000);

        set_op(3'b111, 1'b1, 64'd1);
        {pass_i, add_i, sub_i, xor_i, and_i, or_i} = {6{64'd1}};
        {add_c, add_v, sub_c, sub_v} = 4'b1111;
        step();
        ctrl = 3'b001;
        step();
        in_valid = 1'b0;
        step();
        chk("illegal_status", 64'({i2.out_valid, i2.illegal, i2.flag_n, i2.flag_z, i2.flag_c, i2.flag_v}), 64'b11_1000);
        chk("illegal_result", i2.result, 64'd0);

        set_op(3'b110, 1'b0, 64'hA5);
        step();
        in_valid = 1'b0;
        stall = 1'b1;
        repeat (3) step();
        chk("stall_holds", 64'(i2.out_valid), 64'd0);
        stall = 1'b0;
        step();
        chk("stall_release", 64'({i2.out_valid, i2.result[7:0]}), 64'h1A5);

        set_op(3'b101, 1'b1, 64'd0);
        step();
        in_valid = 1'b0;
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        repeat (2) step();
        chk("flush_kills", 64'({i2.out_valid, i2.flag_n, i2.flag_z, i2.flag_c, i2.flag_v}), 64'b0_1000);

        for (int k = 0; k < 6; k++) begin
            set_op(codes[k], 1'b1, 64'(k + 1));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("stream_last", 64'({i2.out_valid, i2.flag_n, i2.flag_z, i2.flag_c, i2.flag_v, i2.result[7:0]}), 64'h1006);

        for (int n = 0; n < 400; n++) begin
            set_op(3'($urandom), 1'($urandom), rnd64());
            {add_c, add_v, sub_c, sub_v} = 4'($urandom);
            in_valid = $urandom_range(99) < 80;
            stall = $urandom_range(99) < 20;
            flush = $urandom_range(99) < 10;
            reset = $urandom_range(99) < 2;
            step();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
